// File: rtl/attn_value_mac.sv
// Attention value MAC: probability-weighted sum of V rows per lane,
// rounded half-up and saturated back to value precision.
module attn_value_mac #(
  parameter int SEQ_LEN = 3,
  parameter int D_MODEL = 4,
  parameter int V_W     = 8,
  parameter int FRAC_W  = 8,
  parameter int OUT_W   = V_W,
  parameter int ACC_W   = V_W + FRAC_W + $clog2(SEQ_LEN) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [SEQ_LEN*FRAC_W-1:0]  probs,
  output logic                       busy,
  input  logic                       v_valid,
  output logic                       v_ready,
  input  logic [D_MODEL*V_W-1:0]     v_row,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [D_MODEL*OUT_W-1:0]   out_vec
);

  typedef enum logic [1:0] {
    IDLE, ACCUM, ROUND, OUT
  } state_t;

  localparam int CNT_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int PRD_W = V_W + FRAC_W + 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(SEQ_LEN - 1);
  localparam logic signed [ACC_W-1:0] HALF =
    ACC_W'(2 ** (FRAC_W - 1));
  localparam logic signed [ACC_W-1:0] SAT_HI =
    ACC_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  state_t state, state_nx;

  logic [FRAC_W-1:0]       p_q [SEQ_LEN];
  logic [FRAC_W-1:0]       p_sel;
  logic [CNT_W-1:0]        row_cnt;
  logic signed [ACC_W-1:0] acc [D_MODEL];
  logic signed [ACC_W-1:0] acc_nx [D_MODEL];
  logic [OUT_W-1:0]        sat [D_MODEL];

  assign p_sel = p_q[row_cnt];

  for (genvar d = 0; d < D_MODEL; d++) begin : g_lane
    logic signed [PRD_W-1:0] v_x;
    logic signed [PRD_W-1:0] p_x;
    logic signed [PRD_W-1:0] prod;
    logic signed [ACC_W-1:0] rnd;
    logic signed [ACC_W-1:0] shf;

    // Probability is unsigned, so zero-extend before the signed multiply
    assign v_x  = PRD_W'($signed(v_row[d*V_W +: V_W]));
    assign p_x  = $signed(PRD_W'({1'b0, p_sel}));
    assign prod = v_x * p_x;

    assign acc_nx[d] = acc[d] + ACC_W'(prod);
    assign rnd       = acc[d] + HALF;
    assign shf       = rnd >>> FRAC_W;

    always_comb begin
      sat[d] = shf[OUT_W-1:0];
      if (shf > SAT_HI)
        sat[d] = SAT_HI[OUT_W-1:0];
      else if (shf < SAT_LO)
        sat[d] = SAT_LO[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    busy      = (state != IDLE);
    v_ready   = (state == ACCUM);
    out_valid = (state == OUT);
    unique case (state)
      IDLE:  if (start) state_nx = ACCUM;
      ACCUM: begin
        if (v_valid && row_cnt == LAST)
          state_nx = ROUND;
      end
      ROUND: state_nx = OUT;
      OUT:   if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < SEQ_LEN; j++)
        p_q[j] <= '0;
      for (int d = 0; d < D_MODEL; d++)
        acc[d] <= '0;
      row_cnt <= '0;
      out_vec <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            for (int j = 0; j < SEQ_LEN; j++)
              p_q[j] <= probs[j*FRAC_W +: FRAC_W];
            for (int d = 0; d < D_MODEL; d++)
              acc[d] <= '0;
            row_cnt <= '0;
          end
        end
        ACCUM: begin
          if (v_valid) begin
            for (int d = 0; d < D_MODEL; d++)
              acc[d] <= acc_nx[d];
            row_cnt <= row_cnt + CNT_W'(1);
          end
        end
        ROUND: begin
          for (int d = 0; d < D_MODEL; d++)
            out_vec[d*OUT_W +: OUT_W] <= sat[d];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_attn_value_mac.sv
// Directed bench for attn_value_mac: nominal, saturation, rounding,
// backpressure, ignored starts and mid-job reset.
module tb_attn_value_mac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] probs;
  logic        busy;
  logic        v_valid;
  logic        v_ready;
  logic [31:0] v_row;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_vec;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  attn_value_mac dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .probs    (probs),
    .busy     (busy),
    .v_valid  (v_valid),
    .v_ready  (v_ready),
    .v_row    (v_row),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_vec  (out_vec)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int a, input int b,
                                     input int c, input int d);
    logic [31:0] r;
    r[7:0]   = a[7:0];
    r[15:8]  = b[7:0];
    r[23:16] = c[7:0];
    r[31:24] = d[7:0];
    return r;
  endfunction

  function automatic logic [23:0] pp(input int a, input int b,
                                     input int c);
    logic [23:0] r;
    r[7:0]   = a[7:0];
    r[15:8]  = b[7:0];
    r[23:16] = c[7:0];
    return r;
  endfunction

  task automatic start_job(input logic [23:0] p);
    start = 1'b1;
    probs = p;
    @(negedge clk);
    start = 1'b0;
    probs = 24'h0;
    check("vready_rise", v_ready, 1);
  endtask

  task automatic feed(input logic [31:0] r0, input logic [31:0] r1,
                      input logic [31:0] r2, input logic [5:0] pat,
                      input int nrows, input bit mid_start,
                      output int vr_cnt);
    logic [31:0] rows [3];
    int k;
    int cyc;
    logic acc;
    rows[0] = r0;
    rows[1] = r1;
    rows[2] = r2;
    k = 0;
    cyc = 0;
    vr_cnt = 0;
    while (k < nrows && cyc < 50) begin
      v_valid = pat[cyc % 6];
      v_row = v_valid ? rows[k] : 32'hDEADBEEF;
      if (mid_start && cyc == 1) begin
        start = 1'b1;
        probs = 24'hFFFFFF;
      end
      if (v_ready) vr_cnt++;
      acc = v_valid && v_ready;
      @(negedge clk);
      start = 1'b0;
      probs = 24'h0;
      cyc++;
      if (acc) k++;
    end
    v_valid = 1'b0;
    v_row = 32'h0;
    if (k < nrows) check("feed_timeout", k, nrows);
  endtask

  task automatic finish_job(input string tag, input logic [31:0] exp,
                            input int stall, input bit hs_start);
    check({tag, "_round_ov"}, out_valid, 0);
    check({tag, "_round_vr"}, v_ready, 0);
    @(negedge clk);
    check({tag, "_ov_rise"}, out_valid, 1);
    check({tag, "_vec"}, out_vec, exp);
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      @(negedge clk);
      check({tag, "_stall_ov"}, out_valid, 1);
      check({tag, "_stall_vec"}, out_vec, exp);
    end
    out_ready = 1'b1;
    if (hs_start) begin
      start = 1'b1;
      probs = pp(128, 64, 64);
    end
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    probs = 24'h0;
    check({tag, "_ov_drop"}, out_valid, 0);
    check({tag, "_busy_drop"}, busy, 0);
    check({tag, "_vec_hold"}, out_vec, exp);
    if (hs_start) begin
      @(negedge clk);
      check({tag, "_hs_busy"}, busy, 0);
      check({tag, "_hs_vr"}, v_ready, 0);
    end
  endtask

  logic [31:0] nv0, nv1, nv2, nom;
  int vr;

  initial begin
    nv0 = pk(10, 20, -30, 40);
    nv1 = pk(4, 8, -4, 0);
    nv2 = pk(-8, 0, 12, 100);
    nom = pk(4, 12, -13, 45);

    rst_n = 1'b0;
    start = 1'b0;
    probs = 24'h0;
    v_valid = 1'b0;
    v_row = 32'h0;
    out_ready = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_vready", v_ready, 0);
    check("rst_ovalid", out_valid, 0);
    check("rst_vec", out_vec, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    start_job(pp(128, 64, 64));
    feed(nv0, nv1, nv2, 6'b111111, 3, 1'b0, vr);
    check("nom_vready_cycles", vr, 3);
    finish_job("nom", nom, 0, 1'b0);

    start_job(pp(255, 255, 255));
    feed(pk(127, -128, 0, 1), pk(127, -128, 0, 1),
         pk(127, -128, 0, 1), 6'b111111, 3, 1'b0, vr);
    finish_job("sat", pk(127, -128, 0, 3), 0, 1'b0);

    start_job(pp(2, 0, 0));
    feed(pk(64, -64, 127, -1), 32'h0, 32'h0,
         6'b111111, 3, 1'b0, vr);
    finish_job("rnd", pk(1, 0, 1, 0), 0, 1'b0);

    start_job(pp(128, 64, 64));
    feed(nv0, nv1, nv2, 6'b101001, 3, 1'b0, vr);
    finish_job("bp", nom, 5, 1'b0);

    start_job(pp(128, 64, 64));
    feed(nv0, nv1, nv2, 6'b111111, 3, 1'b1, vr);
    finish_job("ign", nom, 0, 1'b1);

    start_job(pp(128, 64, 64));
    feed(nv0, nv1, nv2, 6'b111111, 2, 1'b0, vr);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_vready", v_ready, 0);
    check("mid_rst_ovalid", out_valid, 0);
    check("mid_rst_vec", out_vec, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_job(pp(128, 64, 64));
    feed(nv0, nv1, nv2, 6'b111111, 3, 1'b0, vr);
    finish_job("post_rst", nom, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/attn_value_mac.md
Name: attn_value_mac

Overview:
- Stage directly downstream of the softmax unit in the attention datapath.
- Takes one softmax probability vector (unsigned Q0.FRAC_W, one entry per sequence position) and a stream of SEQ_LEN value rows (D_MODEL signed lanes each).
- Computes the probability-weighted sum of the rows per lane: out[d] = sum over j of p[j]*V[j][d].
- Rounds the result back to value precision with saturation and presents it on a valid/ready output.

Parameters:
- SEQ_LEN, 3: number of probabilities, equal to the number of V rows per job.
- D_MODEL, 4: lanes per V row and per output vector.
- V_W, 8: signed V element width.
- FRAC_W, 8: probability fractional width, Q0.FRAC_W unsigned.
- OUT_W, V_W: signed output element width.
- ACC_W, V_W+FRAC_W+$clog2(SEQ_LEN)+1: signed accumulator width per lane.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a job. Accepted only in IDLE.
- probs  input  SEQ_LEN*FRAC_W  flat probability vector; entry j at bits [j*FRAC_W +: FRAC_W]. Sampled on accepted start.
- busy  output  1  high in every state except IDLE.
- v_valid  input  1  V row valid.
- v_ready  output  1  high exactly while in ACCUM.
- v_row  input  D_MODEL*V_W  signed V row; lane d at bits [d*V_W +: V_W].
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_vec  output  D_MODEL*OUT_W  signed result; lane d at bits [d*OUT_W +: OUT_W].

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy, v_ready and out_valid = 0; out_vec, accumulators, row counter and latched probs = 0.
- The FSM has four states: IDLE, ACCUM, ROUND, OUT.
- IDLE:
  - On start=1: latch probs, clear all accumulators, set row_cnt=0, go to ACCUM.
  - start in any other state is ignored, with no side effects.
- ACCUM:
  - v_ready=1 in this state.
  - On v_valid&&v_ready: acc[d] += signed(v_row[d]) * {1'b0, p[row_cnt]} for every lane in parallel (full-precision product, sign-extended to ACC_W), then row_cnt++.
  - On acceptance of row SEQ_LEN-1, go to ROUND.
  - v_valid low stalls the state indefinitely with no change.
- ROUND (one cycle):
  - out_vec[d] = sat_OUT_W((acc[d] + 2^(FRAC_W-1)) >>> FRAC_W), i.e. arithmetic shift, round half toward +inf.
  - Saturation range is [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Go to OUT.
- OUT:
  - out_valid=1; out_vec is held stable until out_valid&&out_ready.
  - On that handshake: out_valid=0 next cycle, go to IDLE.
  - out_vec keeps its last value after the handshake until the next ROUND.
- Latency:
  - v_ready rises the cycle after the accepted start.
  - out_valid rises 2 cycles after the edge that accepts the last row.
  - Minimum job length: 1 (start) + SEQ_LEN + 1 (ROUND) + 1 (OUT) cycles.
- A start in the same cycle as the OUT handshake is ignored. The next job needs start in IDLE.
- ACC_W is sized so that no accumulator overflow is possible for any input; only the final output saturates.
- Reset mid-job: the job is abandoned immediately; all outputs return to their reset values.

Test Plan:
- Nominal (all tests use defaults):
  - Stimulus: probs={128,64,64}; rows V0={10,20,-30,40}, V1={4,8,-4,0}, V2={-8,0,12,100}, v_valid held high.
  - Required: v_ready high for exactly 3 cycles; out_valid 2 cycles after V2 is accepted; out_vec={4,12,-13,45}.
- Saturation:
  - Stimulus: probs={255,255,255}; all rows={127,-128,0,1}.
  - Required: out_vec={127,-128,0,3}. Lane 3 is (765+128)>>8=3; lanes 0 and 1 clip.
- Rounding:
  - Stimulus: probs={2,0,0}; V0={64,-64,127,-1}, V1 and V2 = 0.
  - Required: out_vec={1,0,1,0}. Lane 0 is +0.5→1, lane 1 is -0.5→0, lane 2 is 254→1, lane 3 is -2→0.
- Backpressure:
  - Stimulus: v_valid toggled 1,0,0,1,0,1 with the nominal rows; out_ready held low for 5 cycles then high.
  - Required: same result as nominal; out_vec and out_valid stable for all 5 stalled cycles; out_valid drops the cycle after the handshake; busy falls with it.
- Ignored start:
  - Stimulus: start pulsed mid-ACCUM with different probs.
  - Required: result is unchanged from the nominal case.
  - Stimulus: start pulsed in the OUT handshake cycle.
  - Required: FSM returns to IDLE and no job begins.
- Reset mid-job:
  - Stimulus: rst_n asserted low after 2 rows have been accepted.
  - Required: busy, v_ready and out_valid are 0 and out_vec=0 immediately. A fresh nominal job after release yields {4,12,-13,45}.
